keypad_digit_loader: RTL and testbench

// - Consumer end of the keypad priority-encoder path in the timer-entry/control level.
// - Takes the encoded key (BCD code, 4'b1111 = no key), debounces press and release,
//   and shifts each accepted digit into a 4-digit MM:SS entry register, right to left.
// - Outputs feed the countdown timer load path and the display mux.

---
 rtl/keypad_digit_loader_pkg.sv | 22 ++
 rtl/keypad_digit_loader_key_press_debouncer.sv | 84 ++++++++
 rtl/keypad_digit_loader.sv | 83 ++++++++
 tb/tb_keypad_digit_loader.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/keypad_digit_loader_pkg.sv
// Shared constants and FSM encoding for the keypad digit loader.
// Imported by the debouncer sub-module and the top-level entry register.
package keypad_digit_loader_pkg;

  localparam int          DIGIT_W    = 4;
  localparam int          MAX_DIGITS = 4;
  localparam logic [3:0]  NO_KEY     = 4'hF;
  localparam logic [3:0]  MAX_BCD    = 4'd9;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_DB   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } kpd_state_e;

  // Codes 10..15 are all treated as "no key".
  function automatic logic is_digit(input logic [3:0] code);
    return code <= MAX_BCD;
  endfunction

endpackage

// File: rtl/keypad_digit_loader_key_press_debouncer.sv
// Press/release debouncer for the encoded keypad code.
// Emits a single accept pulse per clean press; no auto-repeat while held.
module key_press_debouncer
  import keypad_digit_loader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DIGIT_W-1:0]  key_code,
  output logic                accept,
  output logic [DIGIT_W-1:0]  accept_code
);

  kpd_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DIGIT_W-1:0]  cand_q, cand_d;

  logic                key_valid;
  logic [CNT_W-1:0]    cnt_inc;
  logic                cnt_done;

  assign key_valid = is_digit(key_code);
  assign cnt_inc   = cnt_q + CNT_W'(1);
  assign cnt_done  = (cnt_inc == CNT_W'(DEBOUNCE_CYCLES));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cand_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    case (state_q)
      IDLE: begin
        if (key_valid) begin
          cand_d  = key_code;
          cnt_d   = CNT_W'(1);
          state_d = PRESS_DB;
        end
      end
      PRESS_DB: begin
        // A different digit mid-debounce is a glitch, not a new press.
        if (!key_valid || key_code != cand_q) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_done) state_d = HELD;
        end
      end
      HELD: begin
        if (!key_valid) begin
          cnt_d   = CNT_W'(1);
          state_d = RELEASE_DB;
        end
      end
      RELEASE_DB: begin
        if (key_valid) begin
          state_d = HELD;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_done) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    accept      = (state_q == PRESS_DB) && key_valid && (key_code == cand_q) && cnt_done;
    accept_code = cand_q;
  end

endmodule

// File: rtl/keypad_digit_loader.sv
// MM:SS keypad entry register: shifts debounced digits in from the right,
// counts entries up to four and pulses new_digit after each load.
module keypad_digit_loader
  import keypad_digit_loader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  key_code,
  input  logic        enable,
  input  logic        clear,
  output logic [3:0]  sec_ones,
  output logic [3:0]  sec_tens,
  output logic [3:0]  min_ones,
  output logic [3:0]  min_tens,
  output logic [2:0]  digit_cnt,
  output logic        entry_full,
  output logic        new_digit
);

  logic                                  accept;
  logic [DIGIT_W-1:0]                    accept_code;
  logic                                  do_load;

  logic [MAX_DIGITS-1:0][DIGIT_W-1:0]    digits_q, digits_d;
  logic [2:0]                            digit_cnt_q, digit_cnt_d;
  logic                                  entry_full_q, entry_full_d;
  logic                                  new_digit_q, new_digit_d;

  key_press_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_debouncer (
    .clk         (clk),
    .reset       (reset),
    .key_code    (key_code),
    .accept      (accept),
    .accept_code (accept_code)
  );

  // Accepts while disabled or full are dropped; the debouncer still waits for release.
  assign do_load = accept && enable && (digit_cnt_q != 3'(MAX_DIGITS));

  always_comb begin
    digits_d    = digits_q;
    digit_cnt_d = digit_cnt_q;
    new_digit_d = 1'b0;
    if (clear) begin
      digits_d    = '0;
      digit_cnt_d = '0;
    end else if (do_load) begin
      digits_d    = {digits_q[MAX_DIGITS-2:0], accept_code};
      digit_cnt_d = digit_cnt_q + 3'd1;
      new_digit_d = 1'b1;
    end
    entry_full_d = (digit_cnt_d == 3'(MAX_DIGITS));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digits_q     <= '0;
      digit_cnt_q  <= '0;
      entry_full_q <= 1'b0;
      new_digit_q  <= 1'b0;
    end else begin
      digits_q     <= digits_d;
      digit_cnt_q  <= digit_cnt_d;
      entry_full_q <= entry_full_d;
      new_digit_q  <= new_digit_d;
    end
  end

  assign sec_ones   = digits_q[0];
  assign sec_tens   = digits_q[1];
  assign min_ones   = digits_q[2];
  assign min_tens   = digits_q[3];
  assign digit_cnt  = digit_cnt_q;
  assign entry_full = entry_full_q;
  assign new_digit  = new_digit_q;

endmodule

// File: tb/tb_keypad_digit_loader.sv
// Directed bench for keypad_digit_loader: hand-computed expectations,
// inputs driven and outputs sampled on the falling edge.
module tb_keypad_digit_loader;

  logic        clk;
  logic        reset;
  logic [3:0]  key_code;
  logic        enable;
  logic        clear;
  logic [3:0]  sec_ones, sec_tens, min_ones, min_tens;
  logic [2:0]  digit_cnt;
  logic        entry_full;
  logic        new_digit;

  int n_checks = 0;
  int n_pass   = 0;

  keypad_digit_loader #(
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .key_code   (key_code),
    .enable     (enable),
    .clear      (clear),
    .sec_ones   (sec_ones),
    .sec_tens   (sec_tens),
    .min_ones   (min_ones),
    .min_tens   (min_tens),
    .digit_cnt  (digit_cnt),
    .entry_full (entry_full),
    .new_digit  (new_digit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
      $display("check %-24s obs=%0h exp=%0h ok", tag, obs, exp);
    end else begin
      $display("FAIL %-24s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then return to the falling edge for drive/sample.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic hold_key(input logic [3:0] code, input int n);
    key_code = code;
    step(n);
  endtask

  task automatic release_key();
    hold_key(4'hF, 4);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step(1);
    clear = 1'b0;
  endtask

  function automatic logic [15:0] digits();
    return {min_tens, min_ones, sec_tens, sec_ones};
  endfunction

  initial begin
    reset    = 1'b1;
    key_code = 4'hF;
    enable   = 1'b1;
    clear    = 1'b0;
    step(2);
    check_val("reset_digits", digits(), 16'h0000);
    check_val("reset_cnt", digit_cnt, 3'd0);
    check_val("reset_full", entry_full, 1'b0);
    check_val("reset_new", new_digit, 1'b0);
    reset = 1'b0;
    step(1);

    // Key 5: loaded on the 4th edge, pulse for one cycle.
    hold_key(4'd5, 3);
    check_val("k5_edge3_not_loaded", digit_cnt, 3'd0);
    hold_key(4'd5, 1);
    check_val("k5_sec_ones", sec_ones, 4'd5);
    check_val("k5_cnt", digit_cnt, 3'd1);
    check_val("k5_new_pulse", new_digit, 1'b1);
    hold_key(4'd5, 1);
    check_val("k5_new_drop", new_digit, 1'b0);
    release_key();

    // Fill with 1,2,3,0, then a fifth key is ignored.
    do_clear();
    check_val("clear_cnt", digit_cnt, 3'd0);
    check_val("clear_digits", digits(), 16'h0000);
    hold_key(4'd1, 4); release_key();
    hold_key(4'd2, 4); release_key();
    hold_key(4'd3, 4); release_key();
    hold_key(4'd0, 4);
    check_val("zero_counts_new", new_digit, 1'b1);
    release_key();
    check_val("fill_digits", digits(), 16'h1230);
    check_val("fill_cnt", digit_cnt, 3'd4);
    check_val("fill_full", entry_full, 1'b1);
    hold_key(4'd9, 4);
    check_val("full_no_new", new_digit, 1'b0);
    check_val("full_digits_kept", digits(), 16'h1230);
    check_val("full_cnt_kept", digit_cnt, 3'd4);
    release_key();

    // Short press, then release glitch while held.
    do_clear();
    hold_key(4'd4, 3);
    release_key();
    check_val("short_press_cnt", digit_cnt, 3'd0);
    hold_key(4'd4, 4);
    check_val("k4_loaded", sec_ones, 4'd4);
    hold_key(4'hF, 1);
    hold_key(4'd4, 6);
    check_val("glitch_cnt", digit_cnt, 3'd1);
    check_val("glitch_new", new_digit, 1'b0);
    // Key change while held is not a new press.
    hold_key(4'd7, 6);
    check_val("change_held_cnt", digit_cnt, 3'd1);
    release_key();

    // Disabled press, enable raised while held.
    enable = 1'b0;
    hold_key(4'd6, 4);
    check_val("dis_no_new", new_digit, 1'b0);
    enable = 1'b1;
    hold_key(4'd6, 6);
    check_val("dis_held_cnt", digit_cnt, 3'd1);
    check_val("dis_held_digit", sec_ones, 4'd4);
    release_key();
    hold_key(4'd6, 4);
    check_val("repress_digits", digits(), 16'h0046);
    check_val("repress_cnt", digit_cnt, 3'd2);
    release_key();

    // clear coincides with accept of 8.
    do_clear();
    hold_key(4'd1, 4); release_key();
    hold_key(4'd2, 4); release_key();
    check_val("pre_clear_digits", digits(), 16'h0012);
    hold_key(4'd8, 3);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check_val("clr_acc_digits", digits(), 16'h0000);
    check_val("clr_acc_cnt", digit_cnt, 3'd0);
    check_val("clr_acc_new", new_digit, 1'b0);
    hold_key(4'd8, 3);
    check_val("clr_acc_no_reload", digit_cnt, 3'd0);
    release_key();

    // Invalid codes, then reset mid-debounce.
    hold_key(4'd3, 4); release_key();
    hold_key(4'd10, 10);
    hold_key(4'd14, 10);
    release_key();
    check_val("invalid_cnt", digit_cnt, 3'd1);
    check_val("invalid_digit", sec_ones, 4'd3);
    hold_key(4'd7, 2);
    reset = 1'b1;
    #1;
    check_val("async_rst_digits", digits(), 16'h0000);
    check_val("async_rst_cnt", digit_cnt, 3'd0);
    step(1);
    reset = 1'b0;
    step(3);
    check_val("post_rst_edge3", digit_cnt, 3'd0);
    step(1);
    check_val("post_rst_k7", sec_ones, 4'd7);
    check_val("post_rst_cnt", digit_cnt, 3'd1);
    release_key();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
